sort_feeder: RTL and testbench

SORT_FEEDER -- requirements
Module: sort_feeder

---
 rtl/sort_pkg.sv | 17 +
 rtl/sort_feeder_mem.sv | 34 +++
 rtl/sort_feeder.sv | 152 +++++++++++++++
 tb/tb_sort_feeder.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sort_pkg.sv
// Shared types and default sizes for the sort_feeder block.
package sort_pkg;

    // Default data word width and log2 of the maximum packet length.
    localparam int DWIDTH_DEF = 8;
    localparam int AWIDTH_DEF = 3;

    // Feeder control states.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FILL    = 3'd1,
        DISCARD = 3'd2,
        WAIT    = 3'd3,
        SEND    = 3'd4
    } state_t;

endpackage

// File: rtl/sort_feeder_mem.sv
// Packet buffer for sort_feeder: simple dual-port RAM, one write port and
// one registered read port (read data appears one cycle after the address).
module sort_feeder_mem #(
    parameter int DWIDTH = 8,
    parameter int AWIDTH = 3
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              wr_en,
    input  logic [AWIDTH-1:0] wr_addr,
    input  logic [DWIDTH-1:0] wr_data,
    input  logic [AWIDTH-1:0] rd_addr,
    output logic [DWIDTH-1:0] rd_data
);

    logic [DWIDTH-1:0] mem [2**AWIDTH];

    // Storage array; contents survive reset.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read register; cleared on reset so the output word starts at zero.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/sort_feeder.sv
// sort_feeder: collects a source packet into a buffer, then replays it to a
// downstream sorter as one contiguous framed burst once the sorter is free.
// Single-word packets are dropped; packets longer than 2**AWIDTH words are
// truncated and their tail discarded.
// Optional build macro SORT_FEEDER_STAT_EN adds saturating drop/truncation
// counters (drop_cnt_o, trunc_cnt_o).
module sort_feeder
    import sort_pkg::*;
#(
    parameter int DWIDTH = DWIDTH_DEF,
    parameter int AWIDTH = AWIDTH_DEF
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [DWIDTH-1:0] data_i,
    input  logic              val_i,
    input  logic              last_i,
    output logic              ready_o,
    input  logic              busy_i,
    output logic [DWIDTH-1:0] data_o,
    output logic              val_o,
    output logic              sop_o,
    output logic              eop_o
`ifdef SORT_FEEDER_STAT_EN
    ,
    output logic [15:0]       drop_cnt_o,
    output logic [15:0]       trunc_cnt_o
`endif
);

    localparam logic [AWIDTH:0] ONE    = {{AWIDTH{1'b0}}, 1'b1};
    localparam logic [AWIDTH:0] MAXLEN = {1'b1, {AWIDTH{1'b0}}};

    state_t            state_q, state_d;
    logic [AWIDTH:0]   wr_ptr_q, len_q, rd_ptr_q;
    logic [AWIDTH:0]   wr_len, rd_nxt, len_m1;
    logic              wr_en;
    logic [AWIDTH-1:0] rd_addr;

    // Length the packet would have if the word on data_i is accepted now,
    // and the read pointer one word ahead (prefetch for the registered RAM).
    assign wr_len = wr_ptr_q + ONE;
    assign rd_nxt = rd_ptr_q + ONE;
    assign len_m1 = len_q - ONE;

    sort_feeder_mem #(
        .DWIDTH (DWIDTH),
        .AWIDTH (AWIDTH)
    ) u_mem (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr_q[AWIDTH-1:0]),
        .wr_data (data_i),
        .rd_addr (rd_addr),
        .rd_data (data_o)
    );

    // State register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, handshake, framing and buffer addressing.
    always_comb begin
        state_d = state_q;
        ready_o = 1'b0;
        val_o   = 1'b0;
        sop_o   = 1'b0;
        eop_o   = 1'b0;
        wr_en   = 1'b0;
        rd_addr = '0;   // in WAIT word 0 is prefetched so SEND starts at once
        case (state_q)
            IDLE, FILL: begin
                ready_o = 1'b1;
                if (val_i) begin
                    wr_en = 1'b1;
                    if (last_i) begin
                        state_d = (wr_len == ONE) ? IDLE : WAIT;
                    end else if (wr_len == MAXLEN) begin
                        state_d = DISCARD;
                    end else begin
                        state_d = FILL;
                    end
                end
            end
            DISCARD: begin
                ready_o = 1'b1;
                if (val_i && last_i) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (!busy_i) begin
                    state_d = SEND;
                end
            end
            SEND: begin
                val_o   = 1'b1;
                sop_o   = (rd_ptr_q == '0);
                eop_o   = (rd_ptr_q == len_m1);
                rd_addr = rd_nxt[AWIDTH-1:0];
                if (rd_ptr_q == len_m1) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Write pointer, captured packet length and send pointer.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            len_q    <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= (state_d == FILL) ? wr_len : '0;
                len_q    <= wr_len;
            end
            rd_ptr_q <= (state_q == SEND) ? rd_nxt : '0;
        end
    end

`ifdef SORT_FEEDER_STAT_EN
    logic drop_evt, trunc_evt;

    assign drop_evt  = wr_en && last_i && (wr_len == ONE);
    assign trunc_evt = wr_en && !last_i && (wr_len == MAXLEN);

    // Saturating event counters for dropped and truncated packets.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            drop_cnt_o  <= '0;
            trunc_cnt_o <= '0;
        end else begin
            if (drop_evt && drop_cnt_o != 16'hFFFF) begin
                drop_cnt_o <= drop_cnt_o + 16'd1;
            end
            if (trunc_evt && trunc_cnt_o != 16'hFFFF) begin
                trunc_cnt_o <= trunc_cnt_o + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sort_feeder.sv
// Testbench for sort_feeder: directed packets with literal expectations plus
// randomized traffic checked every cycle against a queue-based packet model.
module tb_sort_feeder;

    localparam int DW   = 8;
    localparam int AW   = 3;
    localparam int MAXL = 2**AW;

    logic          clk_i   = 1'b0;
    logic          rst_n_i = 1'b0;
    logic [DW-1:0] data_i  = '0;
    logic          val_i   = 1'b0;
    logic          last_i  = 1'b0;
    logic          busy_i  = 1'b0;
    logic          ready_o;
    logic [DW-1:0] data_o;
    logic          val_o, sop_o, eop_o;
`ifdef SORT_FEEDER_STAT_EN
    logic [15:0]   drop_cnt_o, trunc_cnt_o;
`endif

    int n_chk  = 0;
    int n_fail = 0;
    bit busy_rand = 1'b0;

    sort_feeder #(.DWIDTH(DW), .AWIDTH(AW)) dut (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .data_i  (data_i),
        .val_i   (val_i),
        .last_i  (last_i),
        .ready_o (ready_o),
        .busy_i  (busy_i),
        .data_o  (data_o),
        .val_o   (val_o),
        .sop_o   (sop_o),
        .eop_o   (eop_o)
`ifdef SORT_FEEDER_STAT_EN
        ,
        .drop_cnt_o  (drop_cnt_o),
        .trunc_cnt_o (trunc_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Packets are kept as word queues: words accumulate in pkt_q, a finished
    // packet waits for the sorter to be free, then is replayed from out_q.
    int pkt_q[$];
    int out_q[$];
    bit discarding = 0, pending = 0, sending = 0;
    int out_pos = 0;

    initial begin
        forever begin
            @(negedge clk_i);
            if (!rst_n_i) begin
                pkt_q.delete();
                out_q.delete();
                discarding = 0;
                pending    = 0;
                sending    = 0;
                chk("rst_val", 32'(val_o), 32'd0);
                chk("rst_sop", 32'(sop_o), 32'd0);
                chk("rst_eop", 32'(eop_o), 32'd0);
                chk("rst_data", 32'(data_o), 32'd0);
            end else begin
                chk("m_ready", 32'(ready_o), 32'(!(pending || sending)));
                chk("m_val", 32'(val_o), 32'(sending));
                if (sending) begin
                    chk("m_data", 32'(data_o), 32'(out_q[0]));
                    chk("m_sop", 32'(sop_o), 32'(out_pos == 0));
                    chk("m_eop", 32'(eop_o), 32'(out_q.size() == 1));
                end else begin
                    chk("m_sop_idle", 32'(sop_o), 32'd0);
                    chk("m_eop_idle", 32'(eop_o), 32'd0);
                end
                if (sending) begin
                    void'(out_q.pop_front());
                    out_pos++;
                    if (out_q.size() == 0) sending = 0;
                end else if (pending) begin
                    if (!busy_i) begin
                        out_q   = pkt_q;
                        pkt_q.delete();
                        pending = 0;
                        sending = 1;
                        out_pos = 0;
                    end
                end else if (val_i) begin
                    if (discarding) begin
                        if (last_i) begin
                            discarding = 0;
                            pending    = 1;
                        end
                    end else begin
                        pkt_q.push_back(int'(data_i));
                        if (last_i) begin
                            if (pkt_q.size() == 1) pkt_q.delete();
                            else pending = 1;
                        end else if (pkt_q.size() == MAXL) begin
                            discarding = 1;
                        end
                    end
                end
            end
        end
    end

    // Random sorter back-pressure when enabled.
    initial begin
        forever begin
            @(posedge clk_i);
            #1;
            if (busy_rand) busy_i = ($urandom_range(0, 2) == 0);
        end
    end

    // Drive one packet; returns one time unit after the edge accepting the last word.
    task automatic send_pkt(input int words[$], input bit rnd);
        bit acc;
        int guard;
        for (int i = 0; i < words.size(); i++) begin
            if (rnd && $urandom_range(0, 3) == 0) begin
                val_i  = 1'b0;
                last_i = 1'b0;
                @(posedge clk_i);
                #1;
            end
            data_i = DW'(words[i]);
            val_i  = 1'b1;
            last_i = (i == words.size() - 1);
            guard  = 0;
            acc    = 1'b0;
            while (!acc && guard < 300) begin
                @(negedge clk_i);
                acc = ready_o;
                @(posedge clk_i);
                #1;
                guard++;
            end
            if (!acc) begin
                chk("accept_timeout", 32'd0, 32'd1);
                break;
            end
        end
        val_i  = 1'b0;
        last_i = 1'b0;
    endtask

    task automatic wait_idle();
        int guard = 0;
        do begin
            @(negedge clk_i);
            guard++;
        end while (!(ready_o && !val_o) && guard < 500);
        if (guard >= 500) chk("idle_timeout", 32'd0, 32'd1);
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        int w[$];

        // Reset state
        repeat (2) @(posedge clk_i);
        #2;
        chk("reset_val", 32'(val_o), 32'd0);
        chk("reset_data", 32'(data_o), 32'd0);
        rst_n_i = 1'b1;
        @(negedge clk_i);
        chk("reset_ready", 32'(ready_o), 32'd1);
        @(posedge clk_i);
        #1;

        // 5-word packet, sorter free
        w = '{10, 20, 30, 40, 50};
        send_pkt(w, 0);
        #1;
        chk("p5_n1_val", 32'(val_o), 32'd0);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk_i);
            #2;
            chk("p5_val", 32'(val_o), 32'd1);
            chk("p5_data", 32'(data_o), 32'(10 * (k + 1)));
            chk("p5_sop", 32'(sop_o), 32'(k == 0));
            chk("p5_eop", 32'(eop_o), 32'(k == 4));
        end
        @(posedge clk_i);
        #2;
        chk("p5_after_val", 32'(val_o), 32'd0);
        chk("p5_after_ready", 32'(ready_o), 32'd1);
        @(posedge clk_i);
        #1;

        // 3-word packet held off by a busy sorter
        busy_i = 1'b1;
        w = '{1, 2, 3};
        send_pkt(w, 0);
        for (int k = 0; k < 20; k++) begin
            @(posedge clk_i);
            #2;
            chk("p3_busy_val", 32'(val_o), 32'd0);
            chk("p3_busy_ready", 32'(ready_o), 32'd0);
        end
        busy_i = 1'b0;
        #1;
        chk("p3_fall_val", 32'(val_o), 32'd0);
        @(posedge clk_i);
        #2;
        chk("p3_sop", 32'(sop_o), 32'd1);
        chk("p3_data0", 32'(data_o), 32'd1);
        wait_idle();

        // Single-word packet is dropped
        w = '{77};
        send_pkt(w, 0);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk_i);
            #2;
            chk("p1_val", 32'(val_o), 32'd0);
            chk("p1_ready", 32'(ready_o), 32'd1);
        end
`ifdef SORT_FEEDER_STAT_EN
        chk("p1_drop_cnt", 32'(drop_cnt_o), 32'd1);
`endif
        @(posedge clk_i);
        #1;

        // 12-word packet truncated to 8
        w.delete();
        for (int k = 0; k < 12; k++) w.push_back(100 + k);
        send_pkt(w, 0);
        for (int k = 0; k < 8; k++) begin
            @(posedge clk_i);
            #2;
            chk("p12_val", 32'(val_o), 32'd1);
            chk("p12_data", 32'(data_o), 32'(100 + k));
            chk("p12_eop", 32'(eop_o), 32'(k == 7));
        end
        @(posedge clk_i);
        #2;
        chk("p12_after_val", 32'(val_o), 32'd0);
`ifdef SORT_FEEDER_STAT_EN
        chk("p12_trunc_cnt", 32'(trunc_cnt_o), 32'd1);
`endif
        @(posedge clk_i);
        #1;

        // Reset in the third SEND cycle of an 8-word packet
        w.delete();
        for (int k = 0; k < 8; k++) w.push_back(200 + k);
        send_pkt(w, 0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk_i);
            #2;
            chk("p8_data", 32'(data_o), 32'(200 + k));
        end
        rst_n_i = 1'b0;
        #1;
        chk("p8_rst_val", 32'(val_o), 32'd0);
        chk("p8_rst_eop", 32'(eop_o), 32'd0);
        @(posedge clk_i);
        #2;
        rst_n_i = 1'b1;
        @(posedge clk_i);
        #1;
        w = '{5, 6, 7, 8};
        send_pkt(w, 0);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk_i);
            #2;
            chk("p4_val", 32'(val_o), 32'd1);
            chk("p4_data", 32'(data_o), 32'(5 + k));
            chk("p4_sop", 32'(sop_o), 32'(k == 0));
            chk("p4_eop", 32'(eop_o), 32'(k == 3));
        end
        wait_idle();

        // Randomized traffic with random back-pressure
        busy_rand = 1'b1;
        for (int p = 0; p < 40; p++) begin
            int len;
            len = $urandom_range(1, 12);
            w.delete();
            for (int k = 0; k < len; k++) w.push_back(int'($urandom_range(0, 255)));
            send_pkt(w, 1);
        end
        busy_rand = 1'b0;
        busy_i    = 1'b0;
        wait_idle();
        repeat (3) @(posedge clk_i);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
